// File: rtl/reaction_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : reaction_pkg                                                |
// | Shared types and constants for the reaction-timer trial controller.  |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
package reaction_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      TIMING = 2'd2,
      RESULT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      DISP_WELCOME = 2'd0,
      DISP_NUMBER  = 2'd1
   } disp_mode_t;

   localparam logic [15:0] EARLY_CODE = 16'h9999;
   localparam logic [15:0] BCD_ZERO   = 16'h0000;

   // Binary to four packed BCD digits; used on elaboration-time constants.
   function automatic logic [15:0] to_bcd(input int unsigned v);
      return {4'((v / 1000) % 10), 4'((v / 100) % 10),
              4'((v / 10) % 10),   4'(v % 10)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter4.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : bcd_counter4                                                |
// | Four-digit BCD up-counter with clear, parallel load, increment enable |
// | and a ripple digit-carry chain. Priority: clr > load > inc.           |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module bcd_counter4 (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        inc,
   output logic [15:0] q
);

   logic [3:0]  carry;
   logic [15:0] q_n;

   // Carry chain: a digit advances when every lower digit is at 9 and inc is set.
   always_comb begin
      carry[0] = inc;
      for (int i = 1; i < 4; i++) begin
         carry[i] = carry[i-1] && (q[4*i-4 +: 4] == 4'd9);
      end
      q_n = q;
      if (clr) begin
         q_n = 16'h0000;
      end else if (load) begin
         q_n = load_val;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (carry[i]) begin
               q_n[4*i +: 4] = (q[4*i +: 4] == 4'd9) ? 4'd0 : q[4*i +: 4] + 4'd1;
            end
         end
      end
   end

   // Digit register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= 16'h0000;
      end else begin
         q <= q_n;
      end
   end

endmodule
`default_nettype wire

// File: rtl/reaction_trial_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : reaction_trial_ctrl                                         |
// | Reaction-timer trial sequencer: random pre-stimulus delay, stimulus   |
// | LED, millisecond reaction time in BCD and display-mode select.        |
// | Optional macro REACTION_BEST_TIME_EN keeps the best (lowest) time.    |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module reaction_trial_ctrl
   import reaction_pkg::*;
#(
   parameter int TICK_DIV     = 100_000,
   parameter int RAND_W       = 10,
   parameter int MIN_DELAY_MS = 1000,
   parameter int MAX_MS       = 1000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_p,
   input  logic              clear_p,
   input  logic [RAND_W-1:0] rand_val,
   output logic              rand_adv,
   output logic              led_on,
   output logic [1:0]        disp_mode,
   output logic [15:0]       time_bcd,
   output logic [15:0]       best_bcd
);

   localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   // Wide enough for MIN_DELAY_MS + (2**RAND_W - 1) without overflow.
   localparam int DLY_W = $clog2(MIN_DELAY_MS + (1 << RAND_W));
   // Reaching this value on a tick means the increment lands on the ceiling.
   localparam logic [15:0] BCD_LAST = to_bcd(MAX_MS - 1);

   state_t           state, state_n;
   logic [PS_W-1:0]  presc, presc_n;
   logic [DLY_W-1:0] delay, delay_n;
   logic             led_n, adv_n;
   logic [1:0]       disp_n;
   logic             ms_tick;
   logic             cnt_clr, cnt_load, cnt_inc;

`ifdef REACTION_BEST_TIME_EN
   logic [15:0]      best_q, best_n;
   assign best_bcd = best_q;
`else
   assign best_bcd = BCD_ZERO;
`endif

   assign ms_tick = (presc == PS_W'(TICK_DIV - 1));

   bcd_counter4 u_time (
      .clk      (clk),
      .reset    (reset),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (EARLY_CODE),
      .inc      (cnt_inc),
      .q        (time_bcd)
   );

   // Next-state and next-output logic; any state change restarts the prescaler.
   always_comb begin
      state_n  = state;
      presc_n  = ms_tick ? '0 : presc + PS_W'(1);
      delay_n  = delay;
      led_n    = led_on;
      disp_n   = disp_mode;
      adv_n    = 1'b0;
      cnt_clr  = 1'b0;
      cnt_load = 1'b0;
      cnt_inc  = 1'b0;
`ifdef REACTION_BEST_TIME_EN
      best_n   = best_q;
`endif
      if (clear_p) begin
         state_n = IDLE;
         presc_n = '0;
         led_n   = 1'b0;
         disp_n  = DISP_WELCOME;
         cnt_clr = 1'b1;
      end else begin
         case (state)
            IDLE, RESULT: begin
               presc_n = '0;
               if (start_p) begin
                  state_n = WAIT;
                  delay_n = DLY_W'(MIN_DELAY_MS) + DLY_W'(rand_val);
                  adv_n   = 1'b1;
                  cnt_clr = 1'b1;
                  disp_n  = DISP_NUMBER;
                  led_n   = 1'b0;
               end
            end
            WAIT: begin
               // A press wins even when it coincides with the delay expiring.
               if (start_p) begin
                  state_n  = RESULT;
                  presc_n  = '0;
                  cnt_load = 1'b1;
                  led_n    = 1'b0;
               end else if (ms_tick) begin
                  delay_n = delay - DLY_W'(1);
                  if (delay == DLY_W'(1)) begin
                     state_n = TIMING;
                     presc_n = '0;
                     led_n   = 1'b1;
                  end
               end
            end
            TIMING: begin
               // A press wins over a coincident tick, which is then not counted.
               if (start_p) begin
                  state_n = RESULT;
                  presc_n = '0;
                  led_n   = 1'b0;
`ifdef REACTION_BEST_TIME_EN
                  if (time_bcd < best_q) begin
                     best_n = time_bcd;
                  end
`endif
               end else if (ms_tick) begin
                  cnt_inc = 1'b1;
                  if (time_bcd == BCD_LAST) begin
                     state_n = RESULT;
                     presc_n = '0;
                     led_n   = 1'b0;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         presc     <= '0;
         delay     <= '0;
         led_on    <= 1'b0;
         disp_mode <= DISP_WELCOME;
         rand_adv  <= 1'b0;
      end else begin
         state     <= state_n;
         presc     <= presc_n;
         delay     <= delay_n;
         led_on    <= led_n;
         disp_mode <= disp_n;
         rand_adv  <= adv_n;
      end
   end

`ifdef REACTION_BEST_TIME_EN
   // Best-time register survives clear_p; only reset returns it to 9999.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         best_q <= EARLY_CODE;
      end else begin
         best_q <= best_n;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reaction_trial_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_reaction_trial_ctrl                                      |
// | Self-checking bench for reaction_trial_ctrl (scoreboard queue).       |
// | Honors REACTION_BEST_TIME_EN for best_bcd expectations.               |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module tb_reaction_trial_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start_p = 1'b0;
   logic        clear_p = 1'b0;
   logic [3:0]  rand_val = 4'd0;
   logic        rand_adv, led_on;
   logic [1:0]  disp_mode;
   logic [15:0] time_bcd, best_bcd;

   logic        start2 = 1'b0;
   logic        clear2 = 1'b0;
   logic [3:0]  rand2 = 4'd0;
   logic        adv2, led2;
   logic [1:0]  disp2;
   logic [15:0] time2, best2;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [15:0] exp_q[$];
   logic        led_acc;
   int          k;
   int          lc;

   always #5 clk = ~clk;

   reaction_trial_ctrl #(.TICK_DIV(10), .RAND_W(4), .MIN_DELAY_MS(2), .MAX_MS(20)) dut (
      .clk(clk), .reset(reset), .start_p(start_p), .clear_p(clear_p), .rand_val(rand_val),
      .rand_adv(rand_adv), .led_on(led_on), .disp_mode(disp_mode),
      .time_bcd(time_bcd), .best_bcd(best_bcd));

   reaction_trial_ctrl #(.TICK_DIV(2), .RAND_W(4), .MIN_DELAY_MS(1), .MAX_MS(1000)) dut2 (
      .clk(clk), .reset(reset), .start_p(start2), .clear_p(clear2), .rand_val(rand2),
      .rand_adv(adv2), .led_on(led2), .disp_mode(disp2),
      .time_bcd(time2), .best_bcd(best2));

   function automatic logic [15:0] bcd(input int v);
      logic [15:0] r;
      int t;
      t = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic [15:0] eb(input logic [15:0] v);
`ifdef REACTION_BEST_TIME_EN
      return v;
`else
      return 16'h0000;
`endif
   endfunction

   task automatic push(input logic [15:0] v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [15:0] got);
      logic [15:0] e;
      logic        have;
      have = (exp_q.size() != 0);
      e    = have ? exp_q.pop_front() : 16'h0000;
      n_chk++;
      assert (have && (got === e)) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, e);
      end
   endtask

   task automatic expect_now(input string tag, input logic [15:0] got, input logic [15:0] v);
      push(v);
      chk(tag, got);
   endtask

   task automatic drive_start(input logic [3:0] r);
      @(negedge clk);
      rand_val = r;
      start_p  = 1'b1;
      @(negedge clk);
      start_p  = 1'b0;
   endtask

   task automatic pulse_clear(input logic with_start);
      @(negedge clk);
      clear_p = 1'b1;
      start_p = with_start;
      @(negedge clk);
      clear_p = 1'b0;
      start_p = 1'b0;
   endtask

   task automatic wait_led(input int k0, output int kk);
      kk = k0;
      while (!led_on && kk < 400) begin
         @(negedge clk);
         kk++;
      end
   endtask

   // Press sampled n edges after the current negedge's preceding edge.
   task automatic press_at(input int n);
      repeat (n - 1) begin
         @(negedge clk);
         led_acc |= led_on;
      end
      start_p = 1'b1;
      @(negedge clk);
      start_p = 1'b0;
   endtask

   task automatic watch_ticks(input logic sel, input int last, input int budget, output int led_cnt);
      int          cyc;
      logic [15:0] prev;
      cyc     = 0;
      prev    = sel ? time2 : time_bcd;
      led_cnt = 1;
      for (int v = 1; v <= last; v++) push(bcd(v));
      while (exp_q.size() != 0 && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (sel ? led2 : led_on) led_cnt++;
         if ((sel ? time2 : time_bcd) !== prev) begin
            prev = sel ? time2 : time_bcd;
            chk(sel ? "tick_seq2" : "tick_seq", prev);
         end
      end
      n_chk++;
      assert (exp_q.size() == 0) else begin
         n_fail++;
         $error("FAIL tick_budget: observed %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      expect_now("rst_disp", 16'(disp_mode), 16'd0);
      expect_now("rst_led", 16'(led_on), 16'd0);
      expect_now("rst_time", time_bcd, 16'h0000);
      expect_now("rst_adv", 16'(rand_adv), 16'd0);
      expect_now("rst_best", best_bcd, eb(16'h9999));
      reset = 1'b1;

      // 1: idle for 100 cycles
      led_acc = 1'b0;
      begin
         logic adv_acc;
         logic disp_acc;
         adv_acc = 1'b0;
         disp_acc = 1'b0;
         repeat (100) begin
            @(negedge clk);
            adv_acc  |= rand_adv;
            led_acc  |= led_on;
            disp_acc |= (disp_mode != 2'd0);
         end
         expect_now("idle_adv", 16'(adv_acc), 16'd0);
         expect_now("idle_led", 16'(led_acc), 16'd0);
         expect_now("idle_disp", 16'(disp_acc), 16'd0);
         expect_now("idle_time", time_bcd, 16'h0000);
      end

      // 2: normal trial, delay 2+3 = 5 ms = 50 cycles, press after 7 ticks
      drive_start(4'd3);
      expect_now("t2_adv_hi", 16'(rand_adv), 16'd1);
      expect_now("t2_disp", 16'(disp_mode), 16'd1);
      @(negedge clk);
      expect_now("t2_adv_lo", 16'(rand_adv), 16'd0);
      wait_led(1, k);
      expect_now("t2_led_delay", 16'(k), 16'd50);
      push(16'h0007);
      press_at(71);
      chk("t2_time", time_bcd);
      expect_now("t2_led_off", 16'(led_on), 16'd0);
      expect_now("t2_disp_res", 16'(disp_mode), 16'd1);
      expect_now("t2_best", best_bcd, eb(16'h0007));

      // 3: early press from RESULT
      drive_start(4'd3);
      expect_now("t3_adv", 16'(rand_adv), 16'd1);
      expect_now("t3_time_clr", time_bcd, 16'h0000);
      led_acc = 1'b0;
      press_at(15);
      expect_now("t3_early", time_bcd, 16'h9999);
      expect_now("t3_led_acc", 16'(led_acc | led_on), 16'd0);
      expect_now("t3_best", best_bcd, eb(16'h0007));

      // 3b: press coincident with delay expiry counts as early
      drive_start(4'd0);
      led_acc = 1'b0;
      press_at(20);
      expect_now("t3b_early", time_bcd, 16'h9999);
      expect_now("t3b_led", 16'(led_acc | led_on), 16'd0);

      // 4: timeout at MAX_MS=20, digit carry 0009->0010 in the sequence
      drive_start(4'd0);
      wait_led(0, k);
      expect_now("t4_led_delay", 16'(k), 16'd20);
      watch_ticks(1'b0, 20, 300, lc);
      expect_now("t4_led_cycles", 16'(lc), 16'd200);
      expect_now("t4_led_off", 16'(led_on), 16'd0);
      expect_now("t4_time", time_bcd, 16'h0020);
      expect_now("t4_best", best_bcd, eb(16'h0007));

      // 4b: press coincident with a tick is not counted
      drive_start(4'd0);
      wait_led(0, k);
      press_at(30);
      expect_now("t4b_time", time_bcd, 16'h0002);
      expect_now("t4b_best", best_bcd, eb(16'h0002));

      // 5: clear during TIMING
      drive_start(4'd0);
      wait_led(0, k);
      repeat (15) @(negedge clk);
      pulse_clear(1'b0);
      expect_now("t5_clr_disp", 16'(disp_mode), 16'd0);
      expect_now("t5_clr_led", 16'(led_on), 16'd0);
      expect_now("t5_clr_time", time_bcd, 16'h0000);
      // clear + start together in WAIT
      drive_start(4'd0);
      repeat (5) @(negedge clk);
      pulse_clear(1'b1);
      expect_now("t5_both_disp", 16'(disp_mode), 16'd0);
      expect_now("t5_both_time", time_bcd, 16'h0000);
      led_acc = 1'b0;
      repeat (60) begin
         @(negedge clk);
         led_acc |= led_on;
      end
      expect_now("t5_both_idle", 16'(led_acc), 16'd0);
      // asynchronous reset mid-WAIT
      drive_start(4'd3);
      expect_now("t5_adv_pre", 16'(rand_adv), 16'd1);
      repeat (10) @(negedge clk);
      expect_now("t5_disp_pre", 16'(disp_mode), 16'd1);
      #1 reset = 1'b0;
      #1;
      expect_now("t5_ar_disp", 16'(disp_mode), 16'd0);
      expect_now("t5_ar_led", 16'(led_on), 16'd0);
      expect_now("t5_ar_time", time_bcd, 16'h0000);
      expect_now("t5_ar_best", best_bcd, eb(16'h9999));
      @(negedge clk);
      reset = 1'b1;
      drive_start(4'd3);
      wait_led(0, k);
      expect_now("t5_post_delay", 16'(k), 16'd50);
      pulse_clear(1'b0);

      // 6: best-time sequence 7, 4, early, 9
      drive_start(4'd0); wait_led(0, k); press_at(71);
      expect_now("t6_time7", time_bcd, 16'h0007);
      expect_now("t6_best7", best_bcd, eb(16'h0007));
      drive_start(4'd0); wait_led(0, k); press_at(41);
      expect_now("t6_time4", time_bcd, 16'h0004);
      expect_now("t6_best4", best_bcd, eb(16'h0004));
      drive_start(4'd0); press_at(10);
      expect_now("t6_early", time_bcd, 16'h9999);
      expect_now("t6_best_e", best_bcd, eb(16'h0004));
      drive_start(4'd0); wait_led(0, k); press_at(91);
      expect_now("t6_time9", time_bcd, 16'h0009);
      expect_now("t6_best9", best_bcd, eb(16'h0004));
      pulse_clear(1'b0);
      expect_now("t6_best_clr", best_bcd, eb(16'h0004));
      expect_now("t6_time_clr", time_bcd, 16'h0000);

      // Second instance: MAX_MS=1000, full count including 0999->1000
      @(negedge clk);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      expect_now("d2_adv", 16'(adv2), 16'd1);
      k = 0;
      while (!led2 && k < 20) begin
         @(negedge clk);
         k++;
      end
      expect_now("d2_led_delay", 16'(k), 16'd2);
      watch_ticks(1'b1, 1000, 2500, lc);
      expect_now("d2_led_cycles", 16'(lc), 16'd2000);
      expect_now("d2_led_off", 16'(led2), 16'd0);
      expect_now("d2_time", time2, 16'h1000);
      expect_now("d2_disp", 16'(disp2), 16'd1);
      expect_now("d2_best", best2, eb(16'h9999));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
